// File: rtl/gray_wr_ptr.sv
// Write-side pointer engine for a dual-clock FIFO: binary write pointer, registered Gray export, full flag.
// Optional free-space counter is built when GRAY_WR_PTR_SPACE_EN is defined; otherwise space is tied to 0.
module gray_wr_ptr #(
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  input  logic [AWIDTH:0]   rd_gray_sync,
  output logic              accept,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [AWIDTH:0]   wr_gray,
  output logic              full,
  output logic [AWIDTH:0]   space
);

  localparam logic [AWIDTH:0] ONE   = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

  logic [AWIDTH:0] wr_bin;
  logic [AWIDTH:0] next_bin;
  logic [AWIDTH:0] next_gray;
  logic [AWIDTH:0] full_ptr;
  logic            full_next;

  assign accept  = inc & ~full & ~rst & ~clear;
  assign wr_addr = wr_bin[AWIDTH-1:0];

  // The FIFO is full when the write pointer is exactly one lap ahead of the read pointer;
  // in Gray code that means the top two bits are inverted and the rest match.
  always_comb begin
    next_bin  = wr_bin;
    if (accept) begin
      next_bin = wr_bin + ONE;
    end
    next_gray = next_bin ^ (next_bin >> 1);
    full_ptr  = {~rd_gray_sync[AWIDTH:AWIDTH-1], rd_gray_sync[AWIDTH-2:0]};
    full_next = (next_gray == full_ptr);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_bin  <= '0;
      wr_gray <= '0;
      full    <= 1'b0;
    end else begin
      wr_bin  <= next_bin;
      wr_gray <= next_gray;
      full    <= full_next;
    end
  end

`ifdef GRAY_WR_PTR_SPACE_EN
  logic [AWIDTH:0] rd_bin;
  logic [AWIDTH:0] used;
  logic [AWIDTH:0] space_next;
  logic [AWIDTH:0] space_q;

  // Each binary bit is the XOR of all Gray bits from the MSB down to it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i <= AWIDTH; i++) begin
      rd_bin[i] = ^(rd_gray_sync >> i);
    end
    used       = next_bin - rd_bin;
    space_next = DEPTH - used;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      space_q <= DEPTH;
    end else begin
      space_q <= space_next;
    end
  end

  assign space = space_q;
`else
  assign space = '0;
`endif

endmodule
